mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, the cell-pointer/data width matching memory_unit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, legal range 1..255, the maximum wait for mem_ready.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2, per-requester request valid (bit 0 = port 0, bit 1 = port 1).
REQ-006 SHALL have port req_op0 / req_op1, input, 2 each, op code: 01 car, 10 cdr, 11 cons, 00 none.
REQ-007 SHALL have port req_data0 / req_data1, input, DATA_WIDTH each, operand for memory_unit data_in.
REQ-008 SHALL have port req_ready, output, 2, one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port resp_valid, output, 2, one-cycle response pulse to the granted requester.
REQ-010 SHALL have port resp_data, output, DATA_WIDTH, response data, shared by both requesters, valid with resp_valid.
REQ-011 SHALL have port resp_err, output, 1, timeout flag, valid with resp_valid.
REQ-012 SHALL have port mem_car / mem_cdr / mem_cons, output, 1 each, memory_unit command strobes.
REQ-013 SHALL have port mem_data_in, output, DATA_WIDTH, memory_unit operand.
REQ-014 SHALL have ports mem_data_out (input, DATA_WIDTH) and mem_ready (input, 1), memory_unit result and ready.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT; all outputs registered.
REQ-017 A port SHALL count as requesting only when req_valid is 1 and its op is nonzero; op 00 with valid SHALL be ignored.
REQ-018 IDLE: on an edge with any requesting port, SHALL latch grant, op and data, then go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE (exactly one cycle): SHALL assert exactly one strobe per latched op, drive mem_data_in with the latched data, and pulse req_ready[grant]; next state WAIT.
REQ-020 In WAIT, strobes SHALL be 0, mem_data_in SHALL hold the latched data, and mem_ready SHALL be sampled from the first WAIT cycle onward.
REQ-021 On a WAIT edge with mem_ready=1, SHALL load resp_data<=mem_data_out and resp_err<=0, pulse resp_valid[grant] for one cycle, and go to IDLE.
REQ-022 A wait counter SHALL clear on entry to WAIT; if TIMEOUT_CYCLES WAIT cycles elapse without mem_ready, SHALL pulse resp_valid[grant] with resp_err=1 and resp_data=0, then go to IDLE.
REQ-023 If mem_ready and the timeout occur on the same edge, mem_ready SHALL win (normal response).
REQ-024 Minimum latency SHALL be: accept edge, +1 cycle strobe, +1 WAIT cycle, then resp_valid in the cycle after the ready edge; earliest re-arbitration is in the first IDLE cycle.
REQ-025 A requester SHALL hold valid, op and data until req_ready; the arbiter SHALL never accept twice per request.
REQ-026 resp_data SHALL hold its value between responses.

Reset
REQ-027 On rst=1 at an edge: state<=IDLE; req_ready, resp_valid, resp_err, strobes and busy<=0; resp_data and mem_data_in<=0; wait counter and priority pointer<=0.
REQ-028 Reset mid-transaction SHALL abandon the pending operation with no resp_valid; strobes SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-029 With macro MEM_ARB_RR_EN defined: round-robin, where on a simultaneous request the port not granted last wins and the pointer updates on every grant.
REQ-030 Without MEM_ARB_RR_EN: fixed priority, port 0 always wins ties, and no pointer is kept.

Verification
REQ-031 Port 0 car, data 24'h002405; mem_ready 3 cycles after strobe, mem_data_out 24'h00ABCD -> one mem_car pulse, req_ready[0] once, resp_valid[0] once with resp_data 24'h00ABCD and resp_err 0.
REQ-032 Both ports valid every cycle, 4 transactions, with MEM_ARB_RR_EN -> grants 0,1,0,1; without it -> grants 0,0,0,0.
REQ-033 Port 1 cons, mem_ready held low, TIMEOUT_CYCLES=8 -> resp_valid[1] after 8 WAIT cycles, resp_err 1, resp_data 0, busy falls.
REQ-034 rst pulsed during WAIT -> no resp_valid, busy 0, strobes 0; a new port 1 request is then accepted normally.
REQ-035 req_valid=2'b01 with req_op0=00 -> no strobe, stays IDLE; mem_ready high on the first WAIT edge -> resp_valid on the minimum-latency cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of memory_unit: grants one car/cdr/cons request, waits for mem_ready or a timeout.
// Optional macro MEM_ARB_RR_EN selects round-robin on ties; the default is fixed priority with port 0 winning.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_op0,
    input  logic [1:0]            req_op1,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ready,
    output logic [1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  mem_car,
    output logic                  mem_cdr,
    output logic                  mem_cons,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic                    grant_reg, grant_next;
    logic [7:0]              wait_cnt_reg, wait_cnt_next;
    logic [1:0]              req_ready_reg, req_ready_next;
    logic [1:0]              resp_valid_reg, resp_valid_next;
    logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;
    logic                    resp_err_reg, resp_err_next;
    logic                    car_reg, car_next;
    logic                    cdr_reg, cdr_next;
    logic                    cons_reg, cons_next;
    logic [DATA_WIDTH-1:0]   data_in_reg, data_in_next;
    logic                    busy_reg, busy_next;

    logic [1:0]              req_act;
    logic                    pick;
    logic [1:0]              pick_op;
    logic [DATA_WIDTH-1:0]   pick_data;

    assign req_act[0] = req_valid[0] && (req_op0 != 2'b00);
    assign req_act[1] = req_valid[1] && (req_op1 != 2'b00);

`ifdef MEM_ARB_RR_EN
    // prio_reg names the port that wins the next tie; it flips away from each granted port.
    logic prio_reg, prio_next;

    assign pick      = req_act[1] && (!req_act[0] || prio_reg);
    assign prio_next = (state_reg == IDLE && req_act != 2'b00) ? !pick : prio_reg;

    always_ff @(posedge clk) begin
        if (rst) prio_reg <= 1'b0;
        else     prio_reg <= prio_next;
    end
`else
    assign pick = !req_act[0];
`endif

    assign pick_op   = pick ? req_op1 : req_op0;
    assign pick_data = pick ? req_data1 : req_data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            wait_cnt_reg   <= 8'd0;
            req_ready_reg  <= 2'b00;
            resp_valid_reg <= 2'b00;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            car_reg        <= 1'b0;
            cdr_reg        <= 1'b0;
            cons_reg       <= 1'b0;
            data_in_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            wait_cnt_reg   <= wait_cnt_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
            car_reg        <= car_next;
            cdr_reg        <= cdr_next;
            cons_reg       <= cons_next;
            data_in_reg    <= data_in_next;
            busy_reg       <= busy_next;
        end
    end

    // Outputs are the next-cycle register values; the op is held only as the strobe it produces,
    // and the operand lives in the mem_data_in register for the whole transaction.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        wait_cnt_next   = wait_cnt_reg;
        req_ready_next  = 2'b00;
        resp_valid_next = 2'b00;
        resp_data_next  = resp_data_reg;
        resp_err_next   = 1'b0;
        car_next        = 1'b0;
        cdr_next        = 1'b0;
        cons_next       = 1'b0;
        data_in_next    = data_in_reg;
        case (state_reg)
            IDLE: begin
                if (req_act != 2'b00) begin
                    grant_next     = pick;
                    data_in_next   = pick_data;
                    car_next       = (pick_op == 2'b01);
                    cdr_next       = (pick_op == 2'b10);
                    cons_next      = (pick_op == 2'b11);
                    req_ready_next = pick ? 2'b10 : 2'b01;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = 8'd0;
                state_next    = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    resp_valid_next = grant_reg ? 2'b10 : 2'b01;
                    resp_data_next  = mem_data_out;
                    state_next      = IDLE;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    resp_valid_next = grant_reg ? 2'b10 : 2'b01;
                    resp_data_next  = '0;
                    resp_err_next   = 1'b1;
                    state_next      = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign req_ready   = req_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_data   = resp_data_reg;
    assign resp_err    = resp_err_reg;
    assign mem_car     = car_reg;
    assign mem_cdr     = cdr_reg;
    assign mem_cons    = cons_reg;
    assign mem_data_in = data_in_reg;
    assign busy        = busy_reg;

endmodule
